// File: rtl/float_pkg.sv
// Shared binary32 definitions for the floating-point add/subtract units:
// field widths, special encodings, status codes and the sequencer states.
package float_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = 27;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]      POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_OVF = 2'b01,
        ST_UNF = 2'b10,
        ST_INV = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_OP,
        S_NORM,
        S_ROUND,
        S_FIN
    } state_t;

    // Status for an operand passed straight through (flags denormals).
    function automatic status_t pass_status(input logic [31:0] v);
        return (v[30:23] == '0 && v[22:0] != '0) ? ST_UNF : ST_OK;
    endfunction

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even of a {hidden, 23 fraction, G, R, S} significand.
// A mantissa carry renormalises by one place and bumps the exponent.
module float_round_rne
    import float_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [9:0]       exp_in,
    output logic [23:0]      mant,
    output logic [9:0]       exp_out,
    output logic             carry
);

    logic        inc;
    logic [24:0] sum;

    always_comb begin
        inc     = sig[2] & (sig[1] | sig[0] | sig[3]);
        sum     = {1'b0, sig[26:3]} + {24'd0, inc};
        carry   = sum[24];
        mant    = carry ? sum[24:1] : sum[23:0];
        exp_out = exp_in + {9'd0, carry};
    end

endmodule

// File: rtl/float_subtractor.sv
// Multi-cycle binary32 subtractor diff = x - y, run as an addition with the
// subtrahend sign flipped; one alignment/normalisation shift per cycle.
//
// state    | meaning
// IDLE     | waiting for st, operands latched on accept
// UNPACK   | classify specials/zeros, order operands by exponent
// ALIGN    | shift smaller significand right, down-count to terminal
// OP       | add or subtract aligned significands
// NORM     | carry right-shift or one left shift per cycle
// ROUND    | RNE and pack, overflow/underflow status
// FIN      | publish diff/overflow, pulse done
module float_subtractor
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] diff,
    output logic [1:0]  overflow,
    output logic        done,
    output logic        busy
);

    state_t state, state_nx;

    logic [31:0]      xr, yr, res;
    status_t          res_st;
    logic             sa, sb, sign_r;
    logic [SIG_W-1:0] ma, mb;
    logic [27:0]      m;
    logic [9:0]       exp_r;
    logic [4:0]       cnt;

    logic [EXP_W-1:0]  ex, ey, eax, eay, ediff;
    logic [FRAC_W-1:0] fx, fy;
    logic              x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, special, x_big;
    logic [SIG_W-1:0]  sig_x, sig_y;
    logic [27:0]       op_res;
    logic              op_sign, a_ge, need_norm;
    logic [23:0]       rmant;
    logic [9:0]        rexp;
    logic              rcarry;

    always_comb begin
        ex      = xr[30:23];
        ey      = yr[30:23];
        fx      = xr[22:0];
        fy      = yr[22:0];
        x_nan   = (ex == EXP_MAX) && (fx != '0);
        y_nan   = (ey == EXP_MAX) && (fy != '0);
        x_inf   = (ex == EXP_MAX) && (fx == '0);
        y_inf   = (ey == EXP_MAX) && (fy == '0);
        x_zero  = (ex == '0) && (fx == '0);
        y_zero  = (ey == '0) && (fy == '0);
        special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
        // Denormals: hidden bit 0, effective exponent 1.
        eax     = (ex == '0) ? 8'd1 : ex;
        eay     = (ey == '0) ? 8'd1 : ey;
        sig_x   = {ex != '0, fx, 3'b000};
        sig_y   = {ey != '0, fy, 3'b000};
        x_big   = eax >= eay;
        ediff   = x_big ? (eax - eay) : (eay - eax);

        a_ge    = ma >= mb;
        if (sa == sb) begin
            op_res  = {1'b0, ma} + {1'b0, mb};
            op_sign = sa;
        end else begin
            op_res  = a_ge ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, mb} - {1'b0, ma});
            op_sign = a_ge ? sa : sb;
        end
        need_norm = op_res[27] | (!op_res[26] && exp_r > 10'd1);
    end

    float_round_rne u_round (
        .sig     (m[26:0]),
        .exp_in  (exp_r),
        .mant    (rmant),
        .exp_out (rexp),
        .carry   (rcarry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (st) state_nx = S_UNPACK;
            S_UNPACK: state_nx = special ? S_FIN : ((ediff == '0) ? S_OP : S_ALIGN);
            S_ALIGN:  if (cnt == 5'd1) state_nx = S_OP;
            S_OP:     state_nx = (op_res == '0) ? S_FIN : (need_norm ? S_NORM : S_ROUND);
            S_NORM:   if (m[27] || m[25] || exp_r <= 10'd2) state_nx = S_ROUND;
            S_ROUND:  state_nx = S_FIN;
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff     <= '0;
            overflow <= ST_OK;
            done     <= 1'b0;
            busy     <= 1'b0;
            xr       <= '0;
            yr       <= '0;
            res      <= '0;
            res_st   <= ST_OK;
            sa       <= 1'b0;
            sb       <= 1'b0;
            sign_r   <= 1'b0;
            ma       <= '0;
            mb       <= '0;
            m        <= '0;
            exp_r    <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= st;
                    if (st) begin
                        xr <= x;
                        yr <= {~y[31], y[30:0]};
                    end
                end
                S_UNPACK: begin
                    if (x_nan || y_nan || (x_inf && y_inf && xr[31] != yr[31])) begin
                        res <= QNAN;  res_st <= ST_INV;
                    end else if (x_inf) begin
                        res <= xr;    res_st <= ST_INV;
                    end else if (y_inf) begin
                        res <= yr;    res_st <= ST_INV;
                    end else if (x_zero) begin
                        res <= yr;    res_st <= pass_status(yr);
                    end else if (y_zero) begin
                        res <= xr;    res_st <= pass_status(xr);
                    end
                    // Operand a always carries the larger exponent.
                    if (x_big) begin
                        sa <= xr[31]; ma <= sig_x; sb <= yr[31]; mb <= sig_y;
                        exp_r <= {2'b00, eax};
                    end else begin
                        sa <= yr[31]; ma <= sig_y; sb <= xr[31]; mb <= sig_x;
                        exp_r <= {2'b00, eay};
                    end
                    cnt <= (ediff > 8'd27) ? 5'd27 : ediff[4:0];
                end
                S_ALIGN: begin
                    mb  <= {1'b0, mb[26:2], mb[1] | mb[0]};
                    cnt <= cnt - 5'd1;
                end
                S_OP: begin
                    m      <= op_res;
                    sign_r <= op_sign;
                    res    <= '0;
                    res_st <= ST_OK;
                end
                S_NORM: begin
                    if (m[27]) begin
                        m     <= {1'b0, m[27:2], m[1] | m[0]};
                        exp_r <= exp_r + 10'd1;
                    end else begin
                        m     <= {m[26:0], 1'b0};
                        exp_r <= exp_r - 10'd1;
                    end
                end
                S_ROUND: begin
                    if (rexp >= {2'b00, EXP_MAX}) begin
                        res    <= {sign_r, POS_INF[30:0]};
                        res_st <= ST_OVF;
                    end else if (!rmant[23] && !rcarry) begin
                        res    <= {sign_r, 8'd0, rmant[22:0]};
                        res_st <= (rmant[22:0] != '0) ? ST_UNF : ST_OK;
                    end else begin
                        res    <= {sign_r, rexp[7:0], rmant[22:0]};
                        res_st <= ST_OK;
                    end
                end
                S_FIN: begin
                    diff     <= res;
                    overflow <= res_st;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_subtractor.sv
// Directed-vector bench for float_subtractor: stimulus pushes expected
// results into a queue, a negedge monitor pops and compares on done.
module tb_float_subtractor;

    logic        clk = 1'b0;
    logic        rst, st;
    logic [31:0] x, y, diff;
    logic [1:0]  overflow;
    logic        done, busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        int          c;
    } exp_t;

    exp_t sb_q[$];

    float_subtractor dut (
        .clk      (clk),
        .rst      (rst),
        .st       (st),
        .x        (x),
        .y        (y),
        .diff     (diff),
        .overflow (overflow),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with diff=%h expected no done", diff);
            end else begin
                e = sb_q.pop_front();
                check("diff", diff, e.d);
                check("status", {30'd0, overflow}, {30'd0, e.s});
                check("done_cycle", cyc, e.c);
            end
        end
    end

    // lat: cycles from the start cycle until the one carrying done.
    task automatic run(input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] ed, input logic [1:0] es, input int lat);
        exp_t e;
        @(negedge clk);
        x  = xv;
        y  = yv;
        st = 1'b1;
        e.d = ed;
        e.s = es;
        e.c = cyc + lat;
        sb_q.push_back(e);
        @(negedge clk);
        st = 1'b0;
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done for x=%h y=%h expected diff=%h", xv, yv, ed);
            sb_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        st  = 1'b0;
        x   = '0;
        y   = '0;
        repeat (3) @(negedge clk);
        check("rst_diff", diff, 32'h0);
        check("rst_status", {30'd0, overflow}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;

        run(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00, 6);
        run(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 2'b00, 4);
        run(32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, 2'b00, 29);
        run(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 2'b01, 6);
        run(32'h0080_0000, 32'h0040_0000, 32'h0040_0000, 2'b10, 5);
        run(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 2'b11, 3);
        run(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2'b11, 3);

        // Abort an operation mid-flight: nothing may come out of it.
        @(negedge clk);
        x  = 32'h4B00_0000;
        y  = 32'h3F80_0000;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'h0);
        check("abort_diff", diff, 32'h0);
        check("abort_done", {31'd0, done}, 32'h0);
        repeat (40) @(negedge clk);

        run(32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 2'b00, 29);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
